blockram_access_ctrl: RTL
=========================

BLOCKRAM_ACCESS_CTRL -- requirements
Module: blockram_access_ctrl

Interface
REQ-001 Parameter SINGLE_ENTRY_SIZE_IN_BITS, default 64, SHALL set the data width of every entry.
REQ-002 Parameter NUM_SET, default 64, SHALL set the number of addressable sets.
REQ-003 Parameter SET_PTR_WIDTH_IN_BITS, default 6, SHALL set the set address width.
REQ-004 clk_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_in  input  1  asynchronous, active-high reset.
REQ-006 request_valid_in  input  1  requester holds a valid request.
REQ-007 request_write_in  input  1  1 = write, 0 = read.
REQ-008 request_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  target set.
REQ-009 request_entry_in  input  SINGLE_ENTRY_SIZE_IN_BITS  write data; ignored for reads.
REQ-010 request_ready_out  output  1  controller can accept a request this cycle.
REQ-011 return_valid_out  output  1  response held on return_* outputs.
REQ-012 return_is_write_out  output  1  response belongs to a write.
REQ-013 return_entry_out  output  SINGLE_ENTRY_SIZE_IN_BITS  read data for reads, evicted old data for writes.
REQ-014 return_ack_in  input  1  consumer takes the response.

Function
REQ-015 A request SHALL be accepted on a rising edge where request_valid_in and request_ready_out are both 1; addr, data and type SHALL be registered at that edge.
REQ-016 The FSM SHALL have states INIT, IDLE, ACCESS, CAPTURE and RESPOND; request_ready_out SHALL be 1 only in IDLE.
REQ-017 IDLE -> ACCESS on acceptance; ACCESS -> CAPTURE after exactly one cycle; CAPTURE -> RESPOND after exactly one cycle; RESPOND -> IDLE on the edge where return_ack_in is 1.
REQ-018 In ACCESS, the block SHALL drive the internal RAM as follows: read_en_in = 1 and read_set_addr_in = the registered address; for writes also write_en_in = 1, write_set_addr_in = the registered address and write_entry_in = the registered data. Both enables SHALL be 0 in every other state except INIT.
REQ-019 On the CAPTURE edge, return_entry_out SHALL load read_entry_out for reads and evict_entry_out for writes; return_valid_out SHALL rise on that edge, i.e. 2 edges after acceptance.
REQ-020 While in RESPOND, the return_* outputs SHALL hold stable until acked; the bus SHALL sustain at most one outstanding request.
REQ-021 When return_ack_in is 1 in any state other than RESPOND, it SHALL be ignored; request_* inputs SHALL be ignored whenever request_ready_out is 0.
REQ-022 A request accepted on the same edge as an ack (IDLE reached the previous cycle) SHALL follow the normal timing; minimum throughput SHALL be one request per 4 cycles.
REQ-023 Set addresses SHALL be used unmodified; an address >= NUM_SET SHALL be truncated to SET_PTR_WIDTH_IN_BITS, with no error signalling.

Reset
REQ-024 On reset_in = 1, the block SHALL immediately force the FSM to INIT when BLOCKRAM_CTRL_INIT_EN is defined and to IDLE otherwise, and SHALL force return_valid_out = 0, return_is_write_out = 0, return_entry_out = 0 and the sweep counter = 0.
REQ-025 Reset during ACCESS SHALL abort the request; whether the RAM write completed is unspecified, and no response SHALL be produced.

Configuration
REQ-026 With BLOCKRAM_CTRL_INIT_EN defined, INIT SHALL write zero to sets 0..NUM_SET-1, one set per cycle, using a counter; at count NUM_SET-1 the FSM SHALL go to IDLE. request_ready_out SHALL be 0 during the sweep, which SHALL last exactly NUM_SET cycles.
REQ-027 Without BLOCKRAM_CTRL_INIT_EN, INIT and the counter SHALL be absent, request_ready_out SHALL be 1 in the first cycle after reset, and RAM contents SHALL stay undefined until written.

Structure
REQ-028 The FSM state encoding and the default parameter constants SHALL live in the shared package blockram_ctrl_pkg.
REQ-029 The block SHALL instantiate exactly one sub-module, dual_port_blockram, with the parameters passed through and all of its ports driven only by this FSM.

Verification
REQ-030 With INIT_EN defined: release reset, then read set 5 -> ready = 0 for 64 cycles, then a response of 0x0.
REQ-031 Write 0xFFFFFFFF00000000 to set 63, ack, then read set 63 -> return_entry_out = 0xFFFFFFFF00000000, return_is_write_out = 0, 2 edges after acceptance.
REQ-032 Write 0x00000000FFFFFFFF to set 62, then write 0xFFFFFFFF00000000 to set 62 -> the second response has return_is_write_out = 1 and return_entry_out = 0x00000000FFFFFFFF.
REQ-033 Hold return_ack_in = 0 for 10 cycles -> return_valid_out and return_entry_out stay stable; ready = 0; a request_valid_in pulse carrying 0xDEAD to set 61 is dropped, and set 61 stays unchanged.
REQ-034 Assert reset during ACCESS of a read -> return_valid_out = 0 at once; after recovery, a read of set 63 still returns its last value.
REQ-035 Ack on the response edge and present a new request the next cycle -> accepted immediately; 4-cycle request spacing is sustained across 8 back-to-back requests.

Source files
------------

// File: rtl/blockram_ctrl_pkg.sv
// blockram_ctrl_pkg: shared FSM encoding and default geometry for the block RAM access controller.
// BLOCKRAM_CTRL_INIT_EN adds the INIT zero-fill state and makes it the reset state.
package blockram_ctrl_pkg;
   localparam int DEF_SINGLE_ENTRY_SIZE_IN_BITS = 64;
   localparam int DEF_NUM_SET = 64;
   localparam int DEF_SET_PTR_WIDTH_IN_BITS = 6;
`ifdef BLOCKRAM_CTRL_INIT_EN
   typedef enum logic [2:0] {INIT, IDLE, ACCESS, CAPTURE, RESPOND} ctrl_state_t;
   localparam ctrl_state_t RESET_STATE = INIT;
`else
   typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, RESPOND} ctrl_state_t;
   localparam ctrl_state_t RESET_STATE = IDLE;
`endif
endpackage

// File: rtl/dual_port_blockram.sv
// dual_port_blockram: one registered read port plus one write port that returns the overwritten entry.
module dual_port_blockram
   import blockram_ctrl_pkg::*;
#(
   parameter int SINGLE_ENTRY_SIZE_IN_BITS = DEF_SINGLE_ENTRY_SIZE_IN_BITS,
   parameter int NUM_SET = DEF_NUM_SET,
   parameter int SET_PTR_WIDTH_IN_BITS = DEF_SET_PTR_WIDTH_IN_BITS
) (
   input  logic                                 clk_in,
   input  logic                                 read_en_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     read_set_addr_in,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out,
   input  logic                                 write_en_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     write_set_addr_in,
   input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] evict_entry_out
);
   logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem [NUM_SET];
   // Both reads see the contents from before this edge's write, so evict returns the old entry.
   always_ff @(posedge clk_in) begin
      if (read_en_in) read_entry_out <= mem[read_set_addr_in];
      if (write_en_in) begin
         evict_entry_out <= mem[write_set_addr_in];
         mem[write_set_addr_in] <= write_entry_in;
      end
   end
endmodule

// File: rtl/blockram_access_ctrl.sv
// blockram_access_ctrl: single-outstanding request/response front end for a dual-port block RAM.
// Define BLOCKRAM_CTRL_INIT_EN to zero-fill every set after reset before accepting requests.
module blockram_access_ctrl
   import blockram_ctrl_pkg::*;
#(
   parameter int SINGLE_ENTRY_SIZE_IN_BITS = DEF_SINGLE_ENTRY_SIZE_IN_BITS,
   parameter int NUM_SET = DEF_NUM_SET,
   parameter int SET_PTR_WIDTH_IN_BITS = DEF_SET_PTR_WIDTH_IN_BITS
) (
   input  logic                                 clk_in,
   input  logic                                 reset_in,
   input  logic                                 request_valid_in,
   input  logic                                 request_write_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_set_addr_in,
   input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_entry_in,
   output logic                                 request_ready_out,
   output logic                                 return_valid_out,
   output logic                                 return_is_write_out,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] return_entry_out,
   input  logic                                 return_ack_in
);
   ctrl_state_t state, state_nxt;
   logic [SET_PTR_WIDTH_IN_BITS-1:0] addr_q;
   logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] data_q;
   logic write_q;
   logic ram_rd_en, ram_wr_en;
   logic [SET_PTR_WIDTH_IN_BITS-1:0] ram_rd_addr, ram_wr_addr;
   logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_wr_data, ram_rd_data, ram_evict_data;
   assign request_ready_out = state == IDLE;
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state <= RESET_STATE;
         addr_q <= '0;
         data_q <= '0;
         write_q <= 1'b0;
         return_valid_out <= 1'b0;
         return_is_write_out <= 1'b0;
         return_entry_out <= '0;
      end else begin
         state <= state_nxt;
         if (request_ready_out && request_valid_in) begin
            addr_q <= request_set_addr_in;
            data_q <= request_entry_in;
            write_q <= request_write_in;
         end
         if (state == CAPTURE) begin
            return_valid_out <= 1'b1;
            return_is_write_out <= write_q;
            return_entry_out <= write_q ? ram_evict_data : ram_rd_data;
         end else if (state == RESPOND && return_ack_in) begin
            return_valid_out <= 1'b0;
         end
      end
   end
`ifdef BLOCKRAM_CTRL_INIT_EN
   logic [SET_PTR_WIDTH_IN_BITS-1:0] sweep_cnt;
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) sweep_cnt <= '0;
      else if (state == INIT) sweep_cnt <= sweep_cnt + 1'b1;
   end
`endif
   always_comb begin
      state_nxt = state;
      ram_rd_en = 1'b0;
      ram_wr_en = 1'b0;
      ram_rd_addr = addr_q;
      ram_wr_addr = addr_q;
      ram_wr_data = data_q;
      case (state)
`ifdef BLOCKRAM_CTRL_INIT_EN
         INIT: begin
            ram_wr_en = 1'b1;
            ram_wr_addr = sweep_cnt;
            ram_wr_data = '0;
            if (sweep_cnt == SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1)) state_nxt = IDLE;
         end
`endif
         IDLE: state_nxt = request_valid_in ? ACCESS : IDLE;
         ACCESS: begin
            ram_rd_en = 1'b1;
            ram_wr_en = write_q;
            state_nxt = CAPTURE;
         end
         CAPTURE: state_nxt = RESPOND;
         RESPOND: state_nxt = return_ack_in ? IDLE : RESPOND;
         default: state_nxt = IDLE;
      endcase
   end
   dual_port_blockram #(
      .SINGLE_ENTRY_SIZE_IN_BITS(SINGLE_ENTRY_SIZE_IN_BITS),
      .NUM_SET(NUM_SET),
      .SET_PTR_WIDTH_IN_BITS(SET_PTR_WIDTH_IN_BITS)
   ) u_ram (
      .clk_in(clk_in),
      .read_en_in(ram_rd_en),
      .read_set_addr_in(ram_rd_addr),
      .read_entry_out(ram_rd_data),
      .write_en_in(ram_wr_en),
      .write_set_addr_in(ram_wr_addr),
      .write_entry_in(ram_wr_data),
      .evict_entry_out(ram_evict_data)
   );
endmodule
